// File: rtl/snake_pkg.sv
// Shared key/cell codes, FSM state type and helpers for the snake game datapath.
package snake_pkg;

    localparam int unsigned COORD_W = 8;

    localparam logic [1:0] KEY_W = 2'b00;
    localparam logic [1:0] KEY_A = 2'b01;
    localparam logic [1:0] KEY_S = 2'b11;
    localparam logic [1:0] KEY_D = 2'b10;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BODY  = 2'b01;
    localparam logic [1:0] CELL_FOOD  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        EVAL,
        FOOD,
        DEAD
    } state_t;

    // Opposite directions are bitwise complements: 00<->11, 01<->10.
    function automatic logic [1:0] reverse(input logic [1:0] key);
        return ~key;
    endfunction

endpackage

// File: rtl/snake_food_gen.sv
// Food placement scan index. With SNAKE_FOOD_LFSR_EN defined the scan starts at a
// free-running 16-bit LFSR value mod NCELLS; otherwise it always starts at cell 0.
module snake_food_gen
#(
    parameter int unsigned NCELLS = 100,
    parameter int unsigned IW     = 7
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_scan,
    input  logic          i_found,
    output logic [IW-1:0] o_index
);

    logic [IW-1:0] r_index;
    logic [IW-1:0] w_start_idx;

`ifdef SNAKE_FOOD_LFSR_EN
    logic [15:0] r_lfsr;

    // Fibonacci form, taps 16,15,13,4.
    always_ff @(posedge clk) begin
        if (rst)
            r_lfsr <= 16'hACE1;
        else
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[14] ^ r_lfsr[12] ^ r_lfsr[3]};
    end

    assign w_start_idx = IW'(r_lfsr % 16'(NCELLS));
`else
    assign w_start_idx = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_index <= '0;
        else if (i_start)
            r_index <= w_start_idx;
        else if (i_scan && !i_found)
            r_index <= (r_index == IW'(NCELLS - 1)) ? '0 : r_index + IW'(1);
    end

    assign o_index = r_index;

endmodule

// File: rtl/snake_body_update.sv
// Snake state owner: segment list, length and field map, advanced once per game tick.
// Food placement start is randomised when SNAKE_FOOD_LFSR_EN is defined.
module snake_body_update
    import snake_pkg::*;
#(
    parameter int unsigned SIZE_X = 10,
    parameter int unsigned SIZE_Y = 10,
    parameter int unsigned INIT_X = SIZE_X / 2,
    parameter int unsigned INIT_Y = SIZE_Y / 2
)(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 step,
    input  logic [1:0]                           key,
    input  logic                                 dead,
    input  logic                                 grow,
    output logic                                 check,
    output logic [1:0]                           dir,
    output logic [16*SIZE_X*SIZE_Y-1:0]          snake_xy,
    output logic [2*SIZE_X*SIZE_Y-1:0]           field,
    output logic [$clog2(SIZE_X*SIZE_Y+1)-1:0]   length,
    output logic                                 busy,
    output logic                                 game_over
);

    localparam int unsigned NCELLS = SIZE_X * SIZE_Y;
    localparam int unsigned LW     = $clog2(NCELLS + 1);
    localparam int unsigned CW     = (NCELLS > 1) ? $clog2(NCELLS) : 1;
    localparam int unsigned HEAD0  = INIT_Y * SIZE_X + INIT_X;
    localparam int unsigned FOOD0  = (HEAD0 == 0) ? 1 : 0;

    state_t                  r_state;
    logic [1:0]              r_dir;
    logic                    r_check;
    logic                    r_busy;
    logic                    r_go;
    logic [LW-1:0]           r_len;
    logic [NCELLS-1:0][15:0] r_xy;
    logic [NCELLS-1:0][1:0]  r_field;

    logic [COORD_W-1:0]      w_nx;
    logic [COORD_W-1:0]      w_ny;
    logic                    w_head_in;
    logic [CW-1:0]           w_head_cell;
    logic [CW-1:0]           w_tail_idx;
    logic [CW-1:0]           w_tail_cell;
    logic [15:0]             w_tail_xy;
    logic [CW-1:0]           w_idx;
    logic                    w_start;
    logic                    w_scan;
    logic                    w_found;

    always_comb begin
        w_nx = r_xy[0][7:0];
        w_ny = r_xy[0][15:8];
        case (r_dir)
            KEY_W:   w_ny = r_xy[0][15:8] - 8'd1;
            KEY_A:   w_nx = r_xy[0][7:0]  - 8'd1;
            KEY_S:   w_ny = r_xy[0][15:8] + 8'd1;
            default: w_nx = r_xy[0][7:0]  + 8'd1;
        endcase
    end

    assign w_head_in   = (32'(w_nx) < SIZE_X) && (32'(w_ny) < SIZE_Y);
    assign w_head_cell = CW'(32'(w_ny) * SIZE_X + 32'(w_nx));
    assign w_tail_idx  = CW'(r_len - LW'(1));
    assign w_tail_xy   = r_xy[w_tail_idx];
    assign w_tail_cell = CW'(32'(w_tail_xy[15:8]) * SIZE_X + 32'(w_tail_xy[7:0]));

    assign w_start = (r_state == EVAL) && !dead && grow;
    assign w_scan  = (r_state == FOOD);
    assign w_found = (r_field[w_idx] == CELL_EMPTY);

    snake_food_gen #(
        .NCELLS (NCELLS),
        .IW     (CW)
    ) u_food_gen (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_scan  (w_scan),
        .i_found (w_found),
        .o_index (w_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            r_dir            <= KEY_D;
            r_check          <= 1'b0;
            r_busy           <= 1'b0;
            r_go             <= 1'b0;
            r_len            <= LW'(1);
            r_xy             <= '0;
            r_xy[0]          <= {8'(INIT_Y), 8'(INIT_X)};
            r_field          <= '0;
            r_field[HEAD0]   <= CELL_BODY;
            r_field[FOOD0]   <= CELL_FOOD;
        end else begin
            r_check <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (step) begin
                        r_dir   <= (key == reverse(r_dir)) ? r_dir : key;
                        r_check <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= CHECK;
                    end
                end
                CHECK: r_state <= EVAL;
                EVAL: begin
                    if (dead) begin
                        r_go    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= DEAD;
                    end else begin
                        r_xy <= {r_xy[NCELLS-2:0], w_ny, w_nx};
                        if (grow) begin
                            r_len   <= r_len + LW'(1);
                            r_state <= FOOD;
                        end else begin
                            r_field[w_tail_cell] <= CELL_EMPTY;
                            r_busy               <= 1'b0;
                            r_state              <= IDLE;
                        end
                        // Head write follows the tail clear so it wins when they share a cell.
                        if (w_head_in)
                            r_field[w_head_cell] <= CELL_BODY;
                    end
                end
                FOOD: begin
                    if (r_len == LW'(NCELLS)) begin
                        r_go    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= DEAD;
                    end else if (w_found) begin
                        r_field[w_idx] <= CELL_FOOD;
                        r_busy         <= 1'b0;
                        r_state        <= IDLE;
                    end
                end
                DEAD: r_state <= DEAD;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign check     = r_check;
    assign dir       = r_dir;
    assign snake_xy  = r_xy;
    assign field     = r_field;
    assign length    = r_len;
    assign busy      = r_busy;
    assign game_over = r_go;

endmodule

// File: tb/tb_snake_body_update.sv
// Randomised self-checking bench for snake_body_update (default build, food scan from cell 0).
`timescale 1ns/1ps
module tb_snake_body_update;

    localparam int SX = 10;
    localparam int SY = 10;
    localparam int N  = SX * SY;
    localparam int LW = 7;

    logic            clk = 1'b0;
    logic            rst;
    logic            step;
    logic [1:0]      key;
    logic            dead;
    logic            grow;
    logic            check;
    logic [1:0]      dir;
    logic [16*N-1:0] snake_xy;
    logic [2*N-1:0]  field;
    logic [LW-1:0]   length;
    logic            busy;
    logic            game_over;

    always #5 clk = ~clk;

    snake_body_update #(.SIZE_X(SX), .SIZE_Y(SY)) dut (
        .clk       (clk),
        .rst       (rst),
        .step      (step),
        .key       (key),
        .dead      (dead),
        .grow      (grow),
        .check     (check),
        .dir       (dir),
        .snake_xy  (snake_xy),
        .field     (field),
        .length    (length),
        .busy      (busy),
        .game_over (game_over)
    );

    // Behavioural model: snake as a coordinate list plus a set of food cells.
    int m_sx [N+1];
    int m_sy [N+1];
    bit m_food [N];
    int m_len;
    int m_dir;
    bit m_check;
    bit m_busy;
    bit m_go;
    bit m_valid = 1'b0;

    int n_err = 0;
    int n_chk = 0;

    function automatic void cmp(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic int dxf(input int k);
        return (k == 1) ? -1 : (k == 2) ? 1 : 0;
    endfunction

    function automatic int dyf(input int k);
        return (k == 0) ? -1 : (k == 3) ? 1 : 0;
    endfunction

    function automatic bit is_body(input int c);
        for (int i = 0; i < m_len; i++)
            if (m_sy[i] * SX + m_sx[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int exp_cell(input int c);
        if (is_body(c)) return 1;
        if (m_food[c])  return 2;
        return 0;
    endfunction

    function automatic void model_reset();
        m_len   = 1;
        m_sx[0] = 5;
        m_sy[0] = 5;
        for (int c = 0; c < N; c++) m_food[c] = 1'b0;
        m_food[0] = 1'b1;
        m_dir   = 2;
        m_check = 1'b0;
        m_busy  = 1'b0;
        m_go    = 1'b0;
    endfunction

    // Per-cycle comparison against the model, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                int bad, ba, be;
                cmp("check", int'(check), int'(m_check));
                cmp("busy", int'(busy), int'(m_busy));
                cmp("game_over", int'(game_over), int'(m_go));
                cmp("dir", int'(dir), m_dir);
                cmp("length", int'(length), m_len);
                bad = -1; ba = 0; be = 0;
                for (int c = 0; c < N; c++) begin
                    if (bad < 0 && int'(field[2*c +: 2]) != exp_cell(c)) begin
                        bad = c; ba = int'(field[2*c +: 2]); be = exp_cell(c);
                    end
                end
                n_chk++;
                if (bad >= 0) begin
                    n_err++;
                    $display("FAIL field cell %0d: got %0d expected %0d", bad, ba, be);
                end
                bad = -1; ba = 0; be = 0;
                for (int i = 0; i < m_len; i++) begin
                    if (bad < 0 && int'(snake_xy[16*i +: 16]) != (m_sy[i] << 8 | m_sx[i])) begin
                        bad = i; ba = int'(snake_xy[16*i +: 16]); be = m_sy[i] << 8 | m_sx[i];
                    end
                end
                n_chk++;
                if (bad >= 0) begin
                    n_err++;
                    $display("FAIL snake_xy seg %0d: got 0x%0h expected 0x%0h", bad, ba, be);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        model_reset();
        rst  = 1'b0;
        step = 1'b0;
        dead = 1'b0;
        grow = 1'b0;
    endtask

    // One game tick; the bench plays the collision checker from the model.
    task automatic tick(input int k, input bit fdead, input bit fgrow, input bit rst_food);
        int eff, nx, ny, fc;
        bit inb, g, d;
        eff = (k == 3 - m_dir) ? m_dir : k;
        nx  = (m_sx[0] + dxf(eff)) & 255;
        ny  = (m_sy[0] + dyf(eff)) & 255;
        inb = (nx < SX) && (ny < SY);
        g   = fgrow || (inb && m_food[ny * SX + nx]);
        d   = fdead || !inb;
        if (!d)
            for (int i = 0; i < m_len; i++)
                if ((g || i != m_len - 1) && m_sx[i] == nx && m_sy[i] == ny) d = 1'b1;
        step = 1'b1;
        key  = 2'(k);
        dead = d;
        grow = g;
        cyc();
        m_dir = eff; m_check = 1'b1; m_busy = 1'b1;
        step = 1'($urandom_range(0, 1));
        key  = 2'($urandom_range(0, 3));
        cyc();
        m_check = 1'b0;
        step = 1'($urandom_range(0, 1));
        cyc();
        if (d) begin
            m_go = 1'b1; m_busy = 1'b0; step = 1'b0;
            return;
        end
        for (int i = m_len; i > 0; i--) begin
            m_sx[i] = m_sx[i-1];
            m_sy[i] = m_sy[i-1];
        end
        m_sx[0] = nx;
        m_sy[0] = ny;
        m_food[ny * SX + nx] = 1'b0;
        if (!g) begin
            m_busy = 1'b0; step = 1'b0;
            return;
        end
        m_len++;
        if (m_len == N) begin
            cyc();
            m_go = 1'b1; m_busy = 1'b0; step = 1'b0;
            return;
        end
        fc = 0;
        while (is_body(fc) || m_food[fc]) fc++;
        for (int j = 0; j < fc; j++) cyc();
        if (rst_food) begin
            rst = 1'b1;
            cyc();
            rst = 1'b0;
            model_reset();
            step = 1'b0;
            return;
        end
        cyc();
        m_food[fc] = 1'b1;
        m_busy = 1'b0;
        step = 1'b0;
    endtask

    initial begin
        int pulses;
        rst = 1'b1; step = 1'b0; key = 2'b00; dead = 1'b0; grow = 1'b0;
        cyc();
        cyc();
        model_reset();
        m_valid = 1'b1;
        rst = 1'b0;

        // Reset state literals.
        cmp("rst_length", int'(length), 1);
        cmp("rst_head", int'(snake_xy[15:0]), 'h0505);
        cmp("rst_cell55", int'(field[111:110]), 1);
        cmp("rst_cell0", int'(field[1:0]), 2);
        cmp("rst_dir", int'(dir), 2);
        cmp("rst_busy", int'(busy), 0);

        tick(2, 1'b0, 1'b0, 1'b0);
        cmp("t2_head", int'(snake_xy[15:0]), 'h0506);
        cmp("t2_cell55", int'(field[111:110]), 0);
        cmp("t2_cell56", int'(field[113:112]), 1);
        cmp("t2_length", int'(length), 1);

        tick(1, 1'b0, 1'b0, 1'b0);
        cmp("t3_dir", int'(dir), 2);
        cmp("t3_head", int'(snake_xy[15:0]), 'h0507);

        tick(2, 1'b0, 1'b1, 1'b0);
        cmp("t4_length", int'(length), 2);
        cmp("t4_seg1", int'(snake_xy[31:16]), 'h0507);
        cmp("t4_food_cell1", int'(field[3:2]), 2);
        cmp("t4_busy", int'(busy), 0);

        tick(0, 1'b1, 1'b0, 1'b0);
        cmp("t5_game_over", int'(game_over), 1);
        cmp("t5_head", int'(snake_xy[15:0]), 'h0508);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step = 1'b1;
            key  = 2'($urandom_range(0, 3));
            cyc();
            if (check) pulses++;
        end
        cmp("t5_no_check_in_dead", pulses, 0);
        do_reset();
        cmp("t5_rst_game_over", int'(game_over), 0);

        tick(2, 1'b0, 1'b0, 1'b0);
        tick(2, 1'b0, 1'b1, 1'b1);
        cmp("t6_length", int'(length), 1);
        cmp("t6_head", int'(snake_xy[15:0]), 'h0505);
        cmp("t6_cell1", int'(field[3:2]), 0);
        cmp("t6_cell0", int'(field[1:0]), 2);

        for (int ep = 0; ep < 8; ep++) begin
            do_reset();
            for (int t = 0; t < 150 && !m_go; t++)
                tick(int'($urandom_range(0, 3)), 1'b0, ($urandom_range(0, 5) == 0), 1'b0);
            for (int i = 0; i < 4; i++) begin
                step = 1'($urandom_range(0, 1));
                cyc();
            end
            step = 1'b0;
        end

        m_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/snake_body_update.md
# snake_body_update

Snake state owner for the snake game. Holds the segment coordinate list, length and per-cell field map. On each game tick it drives the collision checker, consumes its `dead`/`grow` verdict, and advances the snake. It sits directly downstream of the collision checker and feeds that checker `snake_xy`, `field` and the effective direction.

## Interface
- `SIZE_X`, default 10: field width in cells (≤255).
- `SIZE_Y`, default 10: field height in cells (≤255).
- `INIT_X`, default `SIZE_X/2`: reset head x.
- `INIT_Y`, default `SIZE_Y/2`: reset head y.
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `step`  in  1  game tick pulse; accepted only in IDLE.
- `key`  in  2  requested direction: 00 w (y−1), 01 a (x−1), 11 s (y+1), 10 d (x+1).
- `dead`  in  1  checker verdict: collision.
- `grow`  in  1  checker verdict: food eaten.
- `check`  out  1  one-cycle strobe to the checker.
- `dir`  out  2  effective direction, wired to the checker's key input.
- `snake_xy`  out  16·SIZE_X·SIZE_Y  segment i at [16i+15:16i]; x in [7:0], y in [15:8]; i=0 is the head.
- `field`  out  2·SIZE_X·SIZE_Y  cell c=y·SIZE_X+x at [2c+1:2c]; 00 empty, 01 body, 10 food.
- `length`  out  clog2(SIZE_X·SIZE_Y+1)  live segments.
- `busy`  out  1  high in any state other than IDLE and DEAD.
- `game_over`  out  1  sticky until `rst`.

## Operation
- States: IDLE, CHECK, EVAL, FOOD, DEAD.
- IDLE + `step`:
  - Latch the effective direction: `key`, unless it is the reverse of the current `dir` (00↔11, 01↔10). A reverse key is ignored and `dir` is kept.
  - Go to CHECK.
- CHECK: `check`=1 for exactly this cycle. Go to EVAL.
- EVAL: sample `dead` and `grow`.
  - `dead`=1: set `game_over`, go to DEAD. No state change to `snake_xy`, `field` or `length`.
  - Otherwise compute new head = head + delta(`dir`) with 8-bit arithmetic. Shift segments down by one position.
  - `grow`=0: clear the old tail cell (segment `length`−1) to 00 first, then write the head cell to 01. This order makes moving into the vacated tail cell legal. `length` is unchanged. Go to IDLE.
  - `grow`=1: write the head cell to 01 (overwriting the food) and keep the tail. `length`+1. Go to FOOD.
- FOOD: scan one cell per cycle from the start index, wrapping at SIZE_X·SIZE_Y−1 → 0.
  - At the first 00 cell, write 10 and go to IDLE.
  - If `length` == SIZE_X·SIZE_Y (no empty cell exists), set `game_over` and go to DEAD without scanning.
- DEAD: terminal. `step` is ignored. Only `rst` exits.
- Segments at index ≥ `length` are don't-care and must never be read into `field`.
- `step` while `busy` or in DEAD is dropped, not queued.

## Timing
- Reset values:
  - State IDLE; `check`=0; `busy`=0; `game_over`=0; `dir`=10; `length`=1.
  - Segment 0 = (INIT_X, INIT_Y). All field cells 00 except the head cell = 01 and cell 0 = 10 (food). If the head is at cell 0, food goes at cell 1.
- Step accepted at edge T:
  - `check` is high in cycle T+1.
  - The checker's registered verdict is valid in cycle T+2 and is sampled in EVAL.
  - `snake_xy`, `field` and `length` update at the end of T+2 (visible from T+3).
- Non-grow tick: 3 cycles from accept to IDLE.
- Grow tick: 3 + (scan cycles, ≥1) cycles.
- `rst` in any state, including mid-FOOD, restores the reset values at the next edge.

## Configuration
- `SNAKE_FOOD_LFSR_EN` defined:
  - A 16-bit maximal LFSR (taps 16,15,13,4; seed 0xACE1 on reset) advances every cycle.
  - The FOOD scan starts at LFSR mod (SIZE_X·SIZE_Y).
- Undefined: the FOOD scan starts at cell 0. Placement is fully deterministic and the LFSR is not instantiated.

## Structure
- Package `snake_pkg`:
  - Key codes (KEY_W/A/S/D).
  - Cell codes (CELL_EMPTY/BODY/FOOD).
  - State enum.
  - Coordinate width constant (8).
  - Function `reverse(key)`.
- Sub-module `snake_food_gen`: the scan index register, plus the LFSR under the macro. Interface is start/found/index.

## Test plan
1. Reset with 10×10 defaults → `length`=1, `snake_xy`[15:0]=0x0505, field cell 55=01, cell 0=10, `dir`=10, `busy`=0.
2. `step` with `key`=10, `dead`=`grow`=0 → `check` high only at T+1; at T+3 head=0x0506, cell 55=00, cell 56=01, `length`=1.
3. Next `step` with `key`=01 while `dir`=10 → reversal ignored, `dir` stays 10, head becomes 0x0507.
4. `grow`=1 at EVAL (macro undefined) → `length`=2, segment 1 = old head, new food written at the first 00 cell from 0, `busy` low afterwards.
5. `dead`=1 at EVAL → `game_over`=1, `snake_xy`/`field` unchanged; later `step` produces no `check`; `rst` clears `game_over`.
6. `rst` asserted during FOOD → next cycle shows the full reset state with no food written.
